// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: round-robin burst arbiter sharing one sync-read ROM between two requesters (ROM_ARB_CHECKSUM_EN adds rd_csum)
module rom_burst_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_dataout,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_id,
  output logic              rd_last,
`ifdef ROM_ARB_CHECKSUM_EN
  output logic [DATA_W-1:0] rd_csum,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_id_q, rd_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic gnt, hs, issue, last;
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: one ISSUE cycle per beat, then a single DRAIN cycle
  always_comb state_d = state_q == IDLE ? (hs ? ISSUE : IDLE) : state_q == ISSUE ? (last ? DRAIN : ISSUE) : IDLE;
  // outputs: pointer's requester wins if valid, otherwise the other one gets ready
  always_comb begin
    gnt = ptr_q ? req1_valid : ~req0_valid;
    req0_ready = state_q == IDLE && !gnt;
    req1_ready = state_q == IDLE && gnt;
    hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    issue = state_q == ISSUE;
    last = issue && cnt_q == '0;
    busy = state_q != IDLE;
  end
  // datapath next values; address holds on the last beat so it stays put through DRAIN/IDLE
  always_comb begin
    ptr_d = hs ? ~gnt : ptr_q;
    id_d = hs ? gnt : id_q;
    addr_d = hs ? (gnt ? req1_addr : req0_addr) : (issue && !last) ? addr_q + 1'b1 : addr_q;
    cnt_d = hs ? (gnt ? req1_len : req0_len) : issue ? cnt_q - 1'b1 : cnt_q;
    rd_valid_d = issue;
    rd_last_d = last;
    rd_id_d = issue ? id_q : rd_id_q;
  end
  // datapath registers; read flags lag issue by one cycle to match ROM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_id_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      id_q <= id_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
      rd_id_q <= rd_id_d;
    end
  end
  assign rom_address = addr_q;
  assign rd_data = rom_dataout;
  assign rd_valid = rd_valid_q;
  assign rd_last = rd_last_q;
  assign rd_id = rd_id_q;
`ifdef ROM_ARB_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  // running sum of earlier beats; the last beat is folded in combinationally
  always_comb begin
    acc_d = hs ? '0 : rd_valid_q ? acc_q + rom_dataout : acc_q;
    rd_csum = rd_last_q ? acc_q + rom_dataout : '0;
  end
  // accumulator register
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
`endif
endmodule
